// File: rtl/fsm_stim_gen.sv
// ---------------------------------------------------------------------------
// fsm_stim_gen
//   Drives the one-wire A line through rise/fall/rise/fall and checks the
//   detector's F/G responses. The dwell per phase and the number of
//   sequences in a burst are latched per request. Completion is reported
//   with Done, and failures with a sticky Err.
//
// Ports
//   Clock      in   single clock, posedge
//   Reset      in   synchronous, active-low
//   Start_req  in   request pulse, only looked at in IDLE
//   Hold       in   [CNT_W]   phase dwell in cycles (0 behaves as 1)
//   Burst      in   [BURST_W] sequences per request (0 behaves as 1)
//   F_in       in   detector F output
//   G_in       in   detector G output
//   A          out  registered drive line to the detector
//   Busy       out  high from the accept edge through the Done cycle
//   Done       out  one-cycle end-of-request pulse
//   Err        out  sticky error, cleared on the next accept
//   Pass_cnt   out  [BURST_W] good sequences in the current/last request
//   Dbg_state  out  [3] current FSM state, for observation only
//
// Request handshake: a request is taken on any posedge where the FSM is
// idle (Busy=0) and Start_req=1. Hold and Burst are captured on that edge.
// While Busy=1, Start_req is ignored, and that includes the Done cycle.
// The earliest new request is the first idle cycle after Done.
// ---------------------------------------------------------------------------
module fsm_stim_gen #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 4,
    parameter int TMO     = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start_req,
    input  logic [CNT_W-1:0]   Hold,
    input  logic [BURST_W-1:0] Burst,
    input  logic               F_in,
    input  logic               G_in,
    output logic               A,
    output logic               Busy,
    output logic               Done,
    output logic               Err,
    output logic [BURST_W-1:0] Pass_cnt,
    output logic [2:0]         Dbg_state
);

    localparam int TMO_W = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RISE1  = 3'd1,
        S_FALL1  = 3'd2,
        S_RISE2  = 3'd3,
        S_FALL2  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   len;      // effective phase length, never 0
    logic [CNT_W-1:0]   dwell;    // cycles already spent in the current phase
    logic [BURST_W-1:0] rem;      // passes still to run, including the current one
    logic [TMO_W-1:0]   tmo_cnt;
    logic               f_seen;
    logic               g_prev;

    logic accept;
    logic phase_end;
    logic g_rise;
    logic tmo_hit;

    // Next-state logic and event decode
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        phase_end = (dwell == (len - CNT_W'(1)));
        g_rise    = G_in & ~g_prev;
        tmo_hit   = (tmo_cnt == TMO_W'(TMO - 1));

        case (state)
            S_IDLE: begin
                if (Start_req) begin
                    accept  = 1'b1;
                    state_n = S_RISE1;
                end
            end
            S_RISE1:  if (phase_end) state_n = S_FALL1;
            S_FALL1:  if (phase_end) state_n = S_RISE2;
            S_RISE2:  if (phase_end) state_n = S_FALL2;
            S_FALL2: begin
                // A G edge takes priority over a timeout that lands on the same edge.
                if (g_rise) begin
                    if (f_seen && (rem > BURST_W'(1))) state_n = S_RISE1;
                    else                               state_n = S_FINISH;
                end else if (tmo_hit) begin
                    state_n = S_FINISH;
                end
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= S_IDLE;
            A        <= 1'b0;
            Err      <= 1'b0;
            Pass_cnt <= '0;
            f_seen   <= 1'b0;
            g_prev   <= 1'b0;
            dwell    <= '0;
            tmo_cnt  <= '0;
            len      <= CNT_W'(1);
            rem      <= '0;
        end else begin
            state  <= state_n;
            g_prev <= G_in;
            // A follows the state being entered, so it is aligned with the state register.
            A      <= (state_n == S_RISE1) || (state_n == S_RISE2);

            // The dwell count restarts whenever a phase changes, including FALL2 -> RISE1.
            if (state_n != state) dwell <= '0;
            else if (state != S_IDLE) dwell <= dwell + CNT_W'(1);

            if ((state == S_FALL2) && (state_n == S_FALL2)) tmo_cnt <= tmo_cnt + TMO_W'(1);
            else                                            tmo_cnt <= '0;

            if ((state == S_FALL1) && (state_n == S_RISE2))
                f_seen <= 1'b0;
            else if (((state == S_RISE2) || (state == S_FALL2)) && F_in)
                f_seen <= 1'b1;

            if (accept) begin
                len      <= (Hold == '0) ? CNT_W'(1) : Hold;
                rem      <= (Burst == '0) ? BURST_W'(1) : Burst;
                Err      <= 1'b0;
                Pass_cnt <= '0;
            end

            if (state == S_FALL2) begin
                if (g_rise && f_seen) begin
                    if (Pass_cnt != '1) Pass_cnt <= Pass_cnt + BURST_W'(1);
                    rem <= rem - BURST_W'(1);
                end
                if ((g_rise && !f_seen) || (!g_rise && tmo_hit)) Err <= 1'b1;
            end
        end
    end

    assign Busy      = (state != S_IDLE);
    assign Done      = (state == S_FINISH);
    assign Dbg_state = state;

endmodule

// File: tb/tb_fsm_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_fsm_stim_gen
//   Bench for fsm_stim_gen. A small behavioural detector can drive F/G from A.
//   Alternatively, F/G can be forced by hand. For each request, the expected
//   {Busy,Done,A} trace is built from the phase-length rules. The final Err and
//   Pass_cnt values are also predicted.
// ---------------------------------------------------------------------------
module tb_fsm_stim_gen;

    localparam int CNT_W   = 8;
    localparam int BURST_W = 4;
    localparam int TMO     = 16;
    localparam int W       = 3;

    // ---------------- clock / reset ----------------
    logic               Clock;
    logic               Reset;
    logic               Start_req;
    logic [CNT_W-1:0]   Hold;
    logic [BURST_W-1:0] Burst;
    logic               F_in, G_in;
    logic               A, Busy, Done, Err;
    logic [BURST_W-1:0] Pass_cnt;
    logic [2:0]         Dbg_state;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    fsm_stim_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W), .TMO(TMO)) dut (
        .Clock(Clock), .Reset(Reset), .Start_req(Start_req), .Hold(Hold),
        .Burst(Burst), .F_in(F_in), .G_in(G_in), .A(A), .Busy(Busy),
        .Done(Done), .Err(Err), .Pass_cnt(Pass_cnt), .Dbg_state(Dbg_state)
    );

    // ---------------- reference detector ----------------
    // F rises on the second A rise. G pulses one cycle on the following A fall.
    logic det_en, f_man, g_man;
    logic det_f, det_g, det_a_prev;
    int   det_rises;

    always @(posedge Clock) begin
        if (!Reset) begin
            det_f <= 1'b0; det_g <= 1'b0; det_a_prev <= 1'b0; det_rises <= 0;
        end else begin
            det_a_prev <= A;
            det_g      <= 1'b0;
            if (A && !det_a_prev) begin
                det_rises <= det_rises + 1;
                if (det_rises == 1) det_f <= 1'b1;
            end else if (!A && det_a_prev && det_f) begin
                det_g     <= 1'b1;
                det_f     <= 1'b0;
                det_rises <= 0;
            end
        end
    end

    assign F_in = det_en ? det_f : f_man;
    assign G_in = det_en ? det_g : g_man;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // mode 0: detector attached, 1: G held low (timeout), 2: F low, G pulsed
    // at FALL2 offset d. stray_k: inject an extra Start_req at sample k
    // (0 = none, 255 = in the Done cycle).
    task automatic run_req(input int hold, input int burst, input int mode,
                           input int d, input int stray_k);
        int L, B, passes, n, sk;
        logic exp_err;
        logic [W-1:0] e;
        L = (hold == 0) ? 1 : hold;
        B = (burst == 0) ? 1 : burst;
        exp_q.delete();
        if (mode == 0) begin
            for (int p = 0; p < B; p++) begin
                for (int i = 0; i < L; i++) exp_q.push_back(3'b101);
                for (int i = 0; i < L; i++) exp_q.push_back(3'b100);
                for (int i = 0; i < L; i++) exp_q.push_back(3'b101);
                exp_q.push_back(3'b100);
                exp_q.push_back(3'b100);
            end
            passes = B; exp_err = 1'b0;
        end else begin
            for (int i = 0; i < L; i++) exp_q.push_back(3'b101);
            for (int i = 0; i < L; i++) exp_q.push_back(3'b100);
            for (int i = 0; i < L; i++) exp_q.push_back(3'b101);
            n = (mode == 1) ? TMO : d + 1;
            for (int i = 0; i < n; i++) exp_q.push_back(3'b100);
            passes = 0; exp_err = 1'b1;
        end
        exp_q.push_back(3'b110);
        if (passes > 15) passes = 15;
        n  = exp_q.size();
        sk = (stray_k == 255) ? n : stray_k;

        det_en = (mode == 0);
        f_man  = (mode == 1);
        g_man  = 1'b0;
        Hold = CNT_W'(hold); Burst = BURST_W'(burst); Start_req = 1'b1;
        step();
        for (int k = 1; k <= n; k++) begin
            e = exp_q.pop_front();
            chk($sformatf("trace k=%0d L=%0d B=%0d m=%0d", k, L, B, mode),
                {29'd0, Busy, Done, A}, {29'd0, e});
            if (k == 1) begin
                chk("err_clr_on_accept", {31'd0, Err}, 32'd0);
                chk("pass_clr_on_accept", {28'd0, Pass_cnt}, 32'd0);
            end
            // Scramble the inputs after the accept edge to show that they were latched.
            Hold      = CNT_W'($urandom_range(0, 255));
            Burst     = BURST_W'($urandom_range(0, 15));
            Start_req = (k == sk);
            g_man     = (mode == 2) && (k == 3 * L + d + 1);
            step();
        end
        Start_req = 1'b0;
        g_man     = 1'b0;
        chk("idle_after_done", {29'd0, Busy, Done, A}, 32'd0);
        chk("err_final", {31'd0, Err}, {31'd0, exp_err});
        chk("pass_final", {28'd0, Pass_cnt}, passes);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        Reset = 1'b0; Start_req = 1'b0; Hold = '0; Burst = '0;
        det_en = 1'b1; f_man = 1'b0; g_man = 1'b0;
        repeat (3) step();
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_a",    {31'd0, A},    32'd0);
        chk("rst_err",  {31'd0, Err},  32'd0);
        chk("rst_pass", {28'd0, Pass_cnt}, 32'd0);
        Reset = 1'b1;
        step();

        run_req(3, 1, 0, 0, 0);      // nominal
        run_req(0, 1, 0, 0, 0);      // minimum dwell
        run_req(2, 1, 1, 0, 0);      // timeout
        run_req(2, 1, 2, 5, 0);      // missing F
        run_req(2, 3, 0, 0, 10);     // burst with an ignored mid-burst request
        run_req(2, 2, 0, 0, 255);    // request in the Done cycle is ignored
        run_req(0, 15, 0, 0, 0);     // full burst, Pass_cnt at its maximum
        run_req(1, 3, 2, 0, 0);      // error on the first pass aborts the burst

        // Reset in the RISE2 phase of the second pass
        det_en = 1'b1; Hold = 8'd3; Burst = 4'd2; Start_req = 1'b1;
        step();
        Start_req = 1'b0;
        repeat (11 + 7) step();
        chk("pre_rst_pass", {28'd0, Pass_cnt}, 32'd1);
        chk("pre_rst_a",    {31'd0, A},        32'd1);
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        chk("mid_rst_a",    {31'd0, A},        32'd0);
        chk("mid_rst_busy", {31'd0, Busy},     32'd0);
        chk("mid_rst_done", {31'd0, Done},     32'd0);
        chk("mid_rst_pass", {28'd0, Pass_cnt}, 32'd0);
        step();
        chk("post_rst_idle", {29'd0, Busy, Done, A}, 32'd0);
        run_req(3, 1, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            int m, h, b, dd, s;
            m  = $urandom_range(0, 3);
            if (m == 3) m = 0;
            h  = $urandom_range(0, 4);
            b  = $urandom_range(0, 4);
            dd = $urandom_range(0, TMO - 2);
            s  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0;
            run_req(h, b, m, dd, s);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fsm_stim_gen.md
# fsm_stim_gen

Stimulus generator for the A-sequence detector: drives a single serial line `A` through the rise/fall/rise/fall sequence (Idle→Start→Stop→Clear→Idle) that the detector decodes. It then checks the detector's `F`/`G` responses. It sits on the driving side of the same one-wire interface and is used for self-test and link bring-up. Phase dwell time and burst count are programmable per request, and the block reports completion and errors.

## Interface
- `CNT_W`, 8: width of the dwell counter and `Hold`.
- `BURST_W`, 4: width of `Burst` and `Pass_cnt`.
- `TMO`, 16: cycles allowed for a `G` rising edge, counted from entry into FALL2.
- `Clock` in 1: single clock, all logic on posedge.
- `Reset` in 1: synchronous, active-low.
- `Start_req` in 1: request pulse, sampled only in IDLE.
- `Hold` in CNT_W: phase dwell in cycles, latched on accept; 0 is treated as 1.
- `Burst` in BURST_W: number of full sequences, latched on accept; 0 is treated as 1.
- `F_in` in 1: detector `F` output.
- `G_in` in 1: detector `G` output.
- `A` out 1: registered drive line to the detector.
- `Busy` out 1: high from accept until the Done cycle, inclusive.
- `Done` out 1: one-cycle pulse at the end of a request.
- `Err` out 1: sticky error flag, cleared on the next accept.
- `Pass_cnt` out BURST_W: sequences passed in the current or last request, cleared on accept.

## Operation
- Reset (`Reset`=0 at a posedge): state IDLE, `A`=0, `Busy`=0, `Done`=0, `Err`=0, `Pass_cnt`=0, internal `f_seen`=0, `g_prev`=0. Reset takes effect mid-sequence on the same edge.
- States: IDLE, RISE1, FALL1, RISE2, FALL2, FINISH.
- Phase length is L = max(Hold,1) cycles.
- IDLE: on `Start_req`=1, latch `Hold` and `Burst`, clear `Err` and `Pass_cnt`, set `Busy`=1, and go to RISE1. Otherwise stay with `A`=0.
- RISE1: `A`=1 for L cycles, then go to FALL1.
- FALL1: `A`=0 for L cycles, then go to RISE2.
- RISE2: `A`=1 for L cycles, then go to FALL2. `f_seen` is cleared on entry to RISE2.
- During RISE2 and FALL2, `F_in`=1 sets `f_seen`.
- FALL2: `A`=0 and the timeout counter runs. A `G` rising edge is `G_in`=1 while `g_prev`=0, where `g_prev` is `G_in` delayed by one cycle.
  - On a `G` rising edge with `f_seen`=1: `Pass_cnt`+1. If passes remaining > 0, go to RISE1; else go to FINISH.
  - On a `G` rising edge with `f_seen`=0: set `Err`=1 and go to FINISH.
  - On reaching TMO cycles with no `G` rising edge: set `Err`=1 and go to FINISH.
- FINISH: `Done`=1 for one cycle, then `Busy`=0 and the state returns to IDLE. `A` stays 0.
- `Start_req` outside IDLE is ignored: no latching and no restart.
- `Start_req` asserted in the FINISH cycle is ignored. It is first eligible in IDLE on the following cycle.
- On an error, the burst aborts immediately and the remaining passes are skipped. `Pass_cnt` holds the count of good passes.
- `Pass_cnt` saturates at 2^BURST_W−1. Counters use no wrap-around.

## Timing
- `A` is registered. Accept happens at edge e0, and `A`=1 is visible after e0.
- Each phase boundary falls exactly L edges after the previous one. RISE1 rises at e0, FALL1 at e0+L, RISE2 at e0+2L, FALL2 at e0+3L.
- With the reference detector attached, `G` is high after edge e0+3L+1.
- The generator samples the `G` rising edge at e0+3L+2.
  - For the last pass, FINISH is entered at e0+3L+2 and `Done` is high in the cycle after that edge.
  - For a non-last pass, the next RISE1 begins at that same edge.
- Timeout: `Err` is set at edge (FALL2 entry)+TMO.
- Throughput: one sequence per 3L+2 cycles in a burst. Minimum IDLE gap between requests is one cycle.

## Test plan
- Nominal pass, detector attached, `Hold`=3, `Burst`=1, `Start_req` at e0 → `A` reads 1,1,1,0,0,0,1,1,1,0… from e0. `Done` pulses after edge e0+11. `Pass_cnt`=1, `Err`=0, `Busy` high for 12 cycles.
- Minimum dwell, `Hold`=0, `Burst`=1 → each `A` phase lasts 1 cycle. `Done` pulses after edge e0+5. `Pass_cnt`=1.
- Timeout, `G_in` tied 0, `Hold`=2 → `Err`=1 and `Done` pulse at FALL2 entry + 16 edges. `Pass_cnt`=0.
- Missing `F`, `F_in` tied 0 and `G_in` pulsed during FALL2 → `Err`=1 and `Done` at the next edge. `Pass_cnt`=0.
- Burst, `Burst`=3, `Hold`=2, detector attached → three back-to-back A sequences of 8 cycles each. One `Done` pulse, `Pass_cnt`=3, `Err`=0. A second `Start_req` mid-burst is ignored.
- Reset mid-op: assert `Reset`=0 during RISE2 → after that edge `A`=0, `Busy`=0, `Pass_cnt`=0, state IDLE. A new request after reset runs nominally.
